// File: rtl/prbg_pattern_detector.sv
// Serial pattern detector for the PRBG output stream: programmable 1..PAT_W bit
// pattern, overlapping or non-overlapping matches, saturating match counter.
//
// state | meaning
// IDLE  | no valid pattern latched; incoming bits are ignored
// FILL  | collecting fresh bits until pat_len have arrived since (re)start
// HUNT  | comparing the window on every accepted bit
module prbg_pattern_detector #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             cfg_err,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

    state_t           st;
    logic [PAT_W-1:0] sh;
    logic [PAT_W-1:0] sh_next;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] fill_rem;
    logic             hit;
    logic             len_ok;
    logic             restart_fill;

    assign sh_next = {sh[PAT_W-2:0], bit_in};
    assign len_ok  = (pat_len != '0) && (int'(pat_len) <= PAT_W);

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    assign hit = (((sh_next ^ pat_q) & mask) == '0);

    // A single-bit pattern never needs refilling: every bit is already fresh.
    assign restart_fill = !overlap && (len_q != LEN_W'(1));

    // fill_rem is a down-counter; the accepted bit that sees 1 completes the window.
    always_ff @(posedge clk) begin
        match <= 1'b0;
        if (res) begin
            st        <= IDLE;
            sh        <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            fill_rem  <= '0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else if (load) begin
            pat_q     <= pat;
            len_q     <= pat_len;
            sh        <= '0;
            fill_rem  <= pat_len;
            match_cnt <= '0;
            cfg_err   <= !len_ok;
            st        <= len_ok ? FILL : IDLE;
        end else if (bit_valid && (st != IDLE)) begin
            sh <= sh_next;
            case (st)
                FILL: begin
                    if (fill_rem == LEN_W'(1)) begin
                        if (hit) begin
                            match <= 1'b1;
                            if (!(&match_cnt)) match_cnt <= match_cnt + CNT_W'(1);
                            if (restart_fill) begin
                                st       <= FILL;
                                fill_rem <= len_q;
                            end else begin
                                st <= HUNT;
                            end
                        end else begin
                            st <= HUNT;
                        end
                    end else begin
                        fill_rem <= fill_rem - LEN_W'(1);
                    end
                end
                HUNT: begin
                    if (hit) begin
                        match <= 1'b1;
                        if (!(&match_cnt)) match_cnt <= match_cnt + CNT_W'(1);
                        if (restart_fill) begin
                            st       <= FILL;
                            fill_rem <= len_q;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign cnt_sat = &match_cnt;
    assign state   = st;

endmodule

// File: tb/tb_prbg_pattern_detector.sv
// Scoreboard bench for prbg_pattern_detector: a behavioural model predicts every
// cycle's outputs, expectations are queued at drive time and popped after the edge.
module tb_prbg_pattern_detector;

    localparam int PAT_W = 8;
    localparam int CNT_W = 3;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             res = 1'b0;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             load = 1'b0;
    logic [PAT_W-1:0] pat = '0;
    logic [LEN_W-1:0] pat_len = '0;
    logic             overlap = 1'b0;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;
    logic             cfg_err;
    logic [1:0]       state;

    prbg_pattern_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .res(res), .bit_in(bit_in), .bit_valid(bit_valid), .load(load),
        .pat(pat), .pat_len(pat_len), .overlap(overlap), .match(match),
        .match_cnt(match_cnt), .cnt_sat(cnt_sat), .cfg_err(cfg_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int m;
        int cnt;
        int st;
        int cfg;
        int sat;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    string phase = "reset";

    // reference model state
    int          m_st = 0;
    int          m_cnt = 0;
    int          m_cfg = 0;
    int          m_len = 0;
    int          m_fresh = 0;
    logic [15:0] m_hist = '0;
    logic [15:0] m_pat = '0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s got=%0d exp=%0d", phase, tag, got, exp);
        end
    endtask

    function automatic bit window_eq();
        for (int i = 0; i < m_len; i++)
            if (m_hist[i] != m_pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_cycle(input logic r, input logic ld, input logic v, input logic b,
                               output int m);
        m = 0;
        if (r) begin
            m_st = 0; m_cnt = 0; m_cfg = 0; m_len = 0; m_fresh = 0;
            m_hist = '0; m_pat = '0;
        end else if (ld) begin
            m_pat   = 16'(pat);
            m_len   = int'(pat_len);
            m_hist  = '0;
            m_fresh = 0;
            m_cnt   = 0;
            m_cfg   = (m_len == 0 || m_len > PAT_W) ? 1 : 0;
            m_st    = m_cfg ? 0 : 1;
        end else if (v && m_st != 0) begin
            m_hist = {m_hist[14:0], b};
            if (m_st == 1) begin
                m_fresh++;
                if (m_fresh == m_len) begin
                    if (window_eq()) begin
                        m = 1;
                        if (!overlap && m_len > 1) m_fresh = 0;
                        else m_st = 2;
                    end else begin
                        m_st = 2;
                    end
                end
            end else if (window_eq()) begin
                m = 1;
                if (!overlap && m_len > 1) begin
                    m_st = 1;
                    m_fresh = 0;
                end
            end
            if (m == 1 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic v, input logic b);
        exp_t e;
        exp_t got;
        int   m;
        @(negedge clk);
        res = r; load = ld; bit_valid = v; bit_in = b;
        model_cycle(r, ld, v, b, m);
        e.m = m; e.cnt = m_cnt; e.st = m_st; e.cfg = m_cfg;
        e.sat = (m_cnt == (1 << CNT_W) - 1) ? 1 : 0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("match", int'(match), got.m);
        chk("match_cnt", int'(match_cnt), got.cnt);
        chk("state", int'(state), got.st);
        chk("cfg_err", int'(cfg_err), got.cfg);
        chk("cnt_sat", int'(cnt_sat), got.sat);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input bit bubbles);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, 1'b0, 1'b1, bits[i]);
            if (bubbles) begin
                int nb;
                nb = $urandom_range(3, 1);
                for (int k = 0; k < nb; k++) step(1'b0, 1'b0, 1'b0, 1'($urandom));
            end
        end
    endtask

    task automatic do_load(input logic [PAT_W-1:0] p, input int len, input logic ov);
        pat = p; pat_len = LEN_W'(len); overlap = ov;
        step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_state", int'(state), 0);
        chk("rst_cnt", int'(match_cnt), 0);

        phase = "overlap";
        do_load(8'b0000_1011, 4, 1'b1);
        send_bits(16'b101_1011, 7, 1'b0);
        chk("final_cnt", int'(match_cnt), 2);
        chk("final_state", int'(state), 2);

        phase = "nonoverlap";
        do_load(8'b0000_1011, 4, 1'b0);
        send_bits(16'b1011, 4, 1'b0);
        chk("state_after4", int'(state), 1);
        send_bits(16'b011, 3, 1'b0);
        chk("cnt_after7", int'(match_cnt), 1);
        send_bits(16'b1011, 4, 1'b0);
        chk("cnt_after11", int'(match_cnt), 2);

        phase = "bubbles";
        do_load(8'b0000_1011, 4, 1'b1);
        send_bits(16'b101_1011, 7, 1'b1);
        chk("final_cnt", int'(match_cnt), 2);

        phase = "cfg_err";
        do_load(8'b0000_1011, 0, 1'b1);
        chk("len0_err", int'(cfg_err), 1);
        chk("len0_state", int'(state), 0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom));
        chk("len0_cnt", int'(match_cnt), 0);
        do_load(8'b0000_1011, 9, 1'b1);
        chk("len9_err", int'(cfg_err), 1);
        do_load(8'b0000_1011, 4, 1'b1);
        chk("ok_err", int'(cfg_err), 0);
        chk("ok_state", int'(state), 1);

        phase = "saturate";
        do_load(8'b0000_0001, 1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("final_cnt", int'(match_cnt), 7);
        chk("final_sat", int'(cnt_sat), 1);

        phase = "priority";
        do_load(8'b0000_1011, 4, 1'b0);
        send_bits(16'b101, 3, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_state", int'(state), 0);
        send_bits(16'b1, 1, 1'b0);
        chk("idle_cnt", int'(match_cnt), 0);
        pat = 8'b0000_1011; pat_len = LEN_W'(4); overlap = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        send_bits(16'b011, 3, 1'b0);
        chk("dropped_cnt", int'(match_cnt), 0);
        send_bits(16'b1011, 4, 1'b0);
        send_bits(16'b011, 3, 1'b0);
        chk("late_cnt", int'(match_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbg_pattern_detector.md
Name: prbg_pattern_detector

Overview:
Receive-side counterpart of the PRBG comparator stream. Consumes the serial 1-bit output of the PRBG and detects a programmable bit pattern of length 1..PAT_W, in overlapping or non-overlapping mode. Emits a one-cycle match pulse, keeps a saturating match counter and exposes FSM state for debug. Sits directly downstream of the PRBG in the same clock domain.

Parameters:
PAT_W, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of the saturating match counter

Ports:
clk  input  1  system clock; all logic on rising edge
res  input  1  synchronous active-high reset
bit_in  input  1  serial data bit (PRBG final_out)
bit_valid  input  1  bit_in is sampled this cycle when high
load  input  1  latch pat and pat_len, restart detection
pat  input  PAT_W  pattern; pat[pat_len-1] is the first-received bit, pat[0] the last
pat_len  input  $clog2(PAT_W+1)  pattern length in bits
overlap  input  1  1 = overlapping matches allowed; sampled every valid bit
match  output  1  one-cycle pulse, high the cycle after the accepting edge
match_cnt  output  CNT_W  number of matches since load/reset, saturating
cnt_sat  output  1  high while match_cnt is all ones
cfg_err  output  1  last load had pat_len == 0 or pat_len > PAT_W
state  output  2  FSM state: 0 IDLE, 1 FILL, 2 HUNT

Behaviour:
- Reset (res=1 at an edge): state=IDLE, match=0, match_cnt=0, cnt_sat=0, cfg_err=0. Shift register, fill counter, pattern and length registers are cleared. res overrides load and bit_valid.
- Shift register sh[PAT_W-1:0]: on an accepted bit, sh <= {sh[PAT_W-2:0], bit_in}. The comparison uses the post-shift value: low pat_len bits of the new sh vs low pat_len bits of the latched pattern. Bits at or above pat_len are ignored.
- Accepted bit: bit_valid=1, load=0, res=0, and state is FILL or HUNT. In IDLE, bits are ignored.
- load=1: latches pat and pat_len, clears sh, fill counter, match and match_cnt. If 1 <= pat_len <= PAT_W, cfg_err=0 and state goes to FILL. Otherwise cfg_err=1 and state goes to IDLE. load wins over a simultaneous bit_valid; that bit is dropped.
- FILL: the fill counter counts accepted bits. When the accepted bit brings the count to pat_len, compare in the same cycle:
  - on equality, match=1 next cycle; state goes to FILL with the counter reset if overlap=0 and pat_len>1, otherwise to HUNT;
  - on inequality, go to HUNT.
- HUNT: compare on every accepted bit.
  - On equality, match=1 next cycle. If overlap=0, go to FILL with the fill counter reset, so pat_len fresh bits are required. If overlap=1, stay in HUNT.
  - With overlap=0 and pat_len=1, stay in HUNT, since each bit is fresh.
- match: exactly one cycle per detection, 0 otherwise. There is no match on any cycle without an accepted bit.
- match_cnt increments together with each match. It holds at 2^CNT_W-1 and never wraps. cnt_sat = &match_cnt.
- Latency: the bit accepted at edge N produces match high from edge N to edge N+1.
- A reset mid-pattern discards all partial history. After reset, a load is required to leave IDLE.
- Bubbles (bit_valid=0) never advance history, never affect matching, and never change state.

Test Plan:
- Overlap: load pat=8'b0000_1011, pat_len=4, overlap=1; stream 1,0,1,1,0,1,1 one per cycle -> match after bits 4 and 7, match_cnt=2, state stays HUNT after bit 4.
- Non-overlap: same stream with overlap=0 -> match only after bit 4, state=FILL after bit 4, match_cnt=1; append 1,0,1,1 -> second match after bit 11.
- Bubbles: the overlap stream with bit_valid low for 1-3 random cycles between bits -> identical match sequence, no extra pulses, match never high on bubble cycles.
- Config error: load with pat_len=0 -> cfg_err=1, state=IDLE, 20 valid bits produce no match. Then load pat_len=9 with PAT_W=8 -> cfg_err=1. Then a valid load -> cfg_err=0, state=FILL.
- Saturation: CNT_W=3, pat_len=1, pat=1, overlap=1, ten consecutive 1s -> ten match pulses, match_cnt stops at 7, cnt_sat=1 from the 7th match on.
- Reset and load priority: res asserted after 3 of 4 pattern bits -> all outputs 0, state=IDLE, and completing the pattern gives no match. Then load with bit_valid=1 in the same cycle -> that bit is dropped, and the pattern is matched only after 4 further bits.
